// File: rtl/pe_accum.sv
// pe_accum: sums KBLK consecutive 2x2 partial products from the matrix PE into
// one output block and presents finished blocks through a 2-entry valid/ready buffer.
module pe_accum #(
  parameter int  WIDTH = 4,
  parameter int  KBLK  = 2,
  parameter int  NBLK  = 4,
  localparam int IN_W  = 2*WIDTH+1,
  localparam int ACC_W = IN_W + $clog2(KBLK),
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_val,
  input  logic [IN_W-1:0]  c11,
  input  logic [IN_W-1:0]  c12,
  input  logic [IN_W-1:0]  c21,
  input  logic [IN_W-1:0]  c22,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [BLK_W-1:0] out_blk,
  output logic             out_last,
  output logic [ACC_W-1:0] d11,
  output logic [ACC_W-1:0] d12,
  output logic [ACC_W-1:0] d21,
  output logic [ACC_W-1:0] d22,
  output logic             ovf,
  output logic             busy
);

  localparam int KC_W = (KBLK > 1) ? $clog2(KBLK) : 1;

  typedef struct packed {
    logic [BLK_W-1:0] blk;
    logic             last;
    logic [ACC_W-1:0] d11;
    logic [ACC_W-1:0] d12;
    logic [ACC_W-1:0] d21;
    logic [ACC_W-1:0] d22;
  } ent_t;

  logic [KC_W-1:0]           kcnt_r;
  logic [BLK_W-1:0]          blkcnt_r;
  logic [3:0][ACC_W-1:0]     acc_r;
  logic [3:0][ACC_W-1:0]     cin_s;
  logic [3:0][ACC_W-1:0]     sum_s;
  logic                      k_first_s;
  logic                      k_last_s;
  logic                      blk_last_s;
  logic                      done_s;
  logic                      pop_s;
  logic                      drop_s;
  ent_t                      new_s;
  ent_t                      head_r, head_n;
  ent_t                      tail_r, tail_n;
  logic                      head_v_r, head_v_n;
  logic                      tail_v_r, tail_v_n;
  logic                      ovf_r;

  assign cin_s      = {ACC_W'(c11), ACC_W'(c12), ACC_W'(c21), ACC_W'(c22)};
  assign k_first_s  = (kcnt_r == KC_W'(0));
  assign k_last_s   = (kcnt_r == KC_W'(KBLK-1));
  assign blk_last_s = (blkcnt_r == BLK_W'(NBLK-1));
  assign done_s     = in_val & k_last_s;
  assign pop_s      = head_v_r & out_rdy;
  assign new_s      = {blkcnt_r, blk_last_s, sum_s};

  // Running sum: the first partial product of a block reloads, later ones add.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < 4; i++) begin
      if (k_first_s) begin
        sum_s[i] = cin_s[i];
      end else begin
        sum_s[i] = acc_r[i] + cin_s[i];
      end
    end
  end

  // Partial-product and block counters plus accumulators; they advance even when a block is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt_r   <= '0;
      blkcnt_r <= '0;
      acc_r    <= '0;
    end else if (clr) begin
      kcnt_r   <= '0;
      blkcnt_r <= '0;
      acc_r    <= '0;
    end else if (in_val) begin
      acc_r <= sum_s;
      if (k_last_s) begin
        kcnt_r   <= KC_W'(0);
        blkcnt_r <= blk_last_s ? BLK_W'(0) : blkcnt_r + BLK_W'(1);
      end else begin
        kcnt_r <= kcnt_r + KC_W'(1);
      end
    end
  end

  // Two-entry buffer next state: head drives the outputs, tail is the overflow slot.
  always_comb begin
    head_n   = head_r;
    tail_n   = tail_r;
    head_v_n = head_v_r;
    tail_v_n = tail_v_r;
    drop_s   = 1'b0;
    case ({head_v_r, tail_v_r})
      2'b00: begin
        if (done_s) begin
          head_n   = new_s;
          head_v_n = 1'b1;
        end else begin
          head_v_n = 1'b0;
        end
      end
      2'b10: begin
        if (done_s && pop_s) begin
          head_n = new_s;
        end else if (done_s) begin
          tail_n   = new_s;
          tail_v_n = 1'b1;
        end else if (pop_s) begin
          head_v_n = 1'b0;
        end else begin
          head_v_n = 1'b1;
        end
      end
      2'b11: begin
        if (pop_s) begin
          head_n = tail_r;
          if (done_s) begin
            tail_n = new_s;
          end else begin
            tail_v_n = 1'b0;
          end
        end else if (done_s) begin
          drop_s = 1'b1;
        end else begin
          drop_s = 1'b0;
        end
      end
      default: begin
        head_v_n = 1'b0;
        tail_v_n = 1'b0;
      end
    endcase
  end

  // Buffer registers and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r   <= '0;
      tail_r   <= '0;
      head_v_r <= 1'b0;
      tail_v_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (clr) begin
      head_r   <= '0;
      tail_r   <= '0;
      head_v_r <= 1'b0;
      tail_v_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      head_r   <= head_n;
      tail_r   <= tail_n;
      head_v_r <= head_v_n;
      tail_v_r <= tail_v_n;
      ovf_r    <= ovf_r | drop_s;
    end
  end

  assign out_val  = head_v_r;
  assign out_blk  = head_r.blk;
  assign out_last = head_r.last;
  assign d11      = head_r.d11;
  assign d12      = head_r.d12;
  assign d21      = head_r.d21;
  assign d22      = head_r.d22;
  assign ovf      = ovf_r;
  assign busy     = (kcnt_r != KC_W'(0)) || (blkcnt_r != BLK_W'(0));

endmodule

// File: tb/tb_pe_accum.sv
// Self-checking bench for pe_accum at default parameters: vector table for the
// streaming cases, hand sequences for backpressure, overflow, reset and clear.
module tb_pe_accum;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_val, out_rdy;
  logic [8:0] c11, c12, c21, c22;
  logic       out_val, out_last, ovf, busy;
  logic [1:0] out_blk;
  logic [9:0] d11, d12, d21, d22;

  int checks = 0;
  int passes = 0;
  logic [42:0] exp_q[$];

  typedef struct packed {
    logic [8:0] c11, c12, c21, c22;
    logic       done;
    logic [9:0] e11, e12, e21, e22;
    logic [1:0] eblk;
    logic       elast;
    logic       ebusy;
  } vec_t;

  vec_t tbl [10];

  pe_accum dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_val(in_val),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_val(out_val), .out_rdy(out_rdy), .out_blk(out_blk), .out_last(out_last),
    .d11(d11), .d12(d12), .d21(d21), .d22(d22), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int a, b, c, d, input logic done,
                              input int ea, eb, ec, ed, input int blk,
                              input logic last, input logic bsy);
    vec_t r;
    r.c11 = 9'(a);   r.c12 = 9'(b);   r.c21 = 9'(c);   r.c22 = 9'(d);
    r.done = done;
    r.e11 = 10'(ea); r.e12 = 10'(eb); r.e21 = 10'(ec); r.e22 = 10'(ed);
    r.eblk = 2'(blk); r.elast = last; r.ebusy = bsy;
    return r;
  endfunction

  task automatic push_exp(input int blk, input logic last, input int a, b, c, d);
    exp_q.push_back({2'(blk), last, 10'(a), 10'(b), 10'(c), 10'(d)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, b, c, d);
    in_val = 1'b1;
    c11 = 9'(a); c12 = 9'(b); c21 = 9'(c); c22 = 9'(d);
    tick();
  endtask

  task automatic drive_all(input int x);
    drive(x, x, x, x);
  endtask

  task automatic idle();
    in_val = 1'b0;
    tick();
  endtask

  // Scoreboard: every handshake seen on the output is compared against the next expected block.
  always @(negedge clk) begin
    if (rst_n && !clr && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: got block %0d d11=%0d with nothing expected", out_blk, d11);
      end else begin
        check("sb_block", {out_blk, out_last, d11, d12, d21, d22}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk( 10,  20,  30,  40, 1'b0,   0,   0,   0,    0, 0, 1'b0, 1'b1);
    tbl[1] = mk(  1,   2,   3,   4, 1'b1,  11,  22,  33,   44, 0, 1'b0, 1'b1);
    tbl[2] = mk(450, 450, 450, 450, 1'b0,   0,   0,   0,    0, 0, 1'b0, 1'b1);
    tbl[3] = mk(450, 450, 450, 450, 1'b1, 900, 900, 900,  900, 1, 1'b0, 1'b1);
    tbl[4] = mk(  5,   6,   7,   8, 1'b0,   0,   0,   0,    0, 0, 1'b0, 1'b1);
    tbl[5] = mk(  0,   0,   0,   0, 1'b1,   5,   6,   7,    8, 2, 1'b0, 1'b1);
    tbl[6] = mk(100,   0, 255, 511, 1'b0,   0,   0,   0,    0, 0, 1'b0, 1'b1);
    tbl[7] = mk(  1, 511,   1, 511, 1'b1, 101, 511, 256, 1022, 3, 1'b1, 1'b0);
    tbl[8] = mk(  7,   7,   7,   7, 1'b0,   0,   0,   0,    0, 0, 1'b0, 1'b1);
    tbl[9] = mk(  3,   3,   3,   3, 1'b1,  10,  10,  10,   10, 0, 1'b0, 1'b1);

    rst_n = 1'b0; clr = 1'b0; in_val = 1'b0; out_rdy = 1'b1;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0;
    tick(); tick();
    check("reset_state", {out_val, out_blk, out_last, d11, d12, d21, d22, ovf, busy}, 64'd0);
    rst_n = 1'b1;

    // Streaming: basic sum, width boundary, reload, full matrix and wrap to block 0.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].done) push_exp(tbl[i].eblk, tbl[i].elast, tbl[i].e11, tbl[i].e12, tbl[i].e21, tbl[i].e22);
      drive(tbl[i].c11, tbl[i].c12, tbl[i].c21, tbl[i].c22);
      check("row_out_val", out_val, tbl[i].done);
      if (tbl[i].done) check("row_out_blk", out_blk, tbl[i].eblk);
      check("row_busy", busy, tbl[i].ebusy);
    end
    idle(); idle();
    check("stream_drained", exp_q.size(), 0);
    check("stream_ovf", ovf, 0);

    // Backpressure: blocks 0 and 1 held, block 2 dropped, indexing stays aligned.
    clr = 1'b1; idle(); clr = 1'b0;
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) push_exp(k, 1'b0, 2*(k+1), 2*(k+1), 2*(k+1), 2*(k+1));
      drive_all(k+1);
      drive_all(k+1);
      check("bp_head_blk", out_blk, 0);
      check("bp_head_d11", d11, 2);
      check("bp_ovf", ovf, (k == 2) ? 1 : 0);
    end
    out_rdy = 1'b1;
    idle(); idle();
    check("bp_empty_after_pops", out_val, 0);
    push_exp(3, 1'b1, 18, 18, 18, 18);
    drive_all(9);
    drive_all(9);
    check("bp_next_val", out_val, 1);
    check("bp_next_blk", out_blk, 3);
    idle();
    check("bp_drained", exp_q.size(), 0);
    check("bp_ovf_sticky", ovf, 1);

    // Full buffer: a completion coincides with a pop and must not drop.
    clr = 1'b1; idle(); clr = 1'b0;
    out_rdy = 1'b0;
    push_exp(0, 1'b0, 3, 3, 3, 3);
    drive_all(1); drive_all(2);
    push_exp(1, 1'b0, 7, 7, 7, 7);
    drive_all(3); drive_all(4);
    drive_all(5);
    out_rdy = 1'b1;
    push_exp(2, 1'b0, 11, 11, 11, 11);
    drive_all(6);
    check("pp_head_blk", out_blk, 1);
    check("pp_ovf", ovf, 0);
    idle(); idle();
    check("pp_drained", exp_q.size(), 0);
    check("pp_ovf_final", ovf, 0);

    // Asynchronous reset mid-accumulation.
    drive_all(1);
    in_val = 1'b0;
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {out_val, out_blk, out_last, d11, d12, d21, d22, ovf, busy}, 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    push_exp(0, 1'b0, 2, 2, 2, 2);
    drive_all(1); drive_all(1);
    idle();
    check("rst_drained", exp_q.size(), 0);

    // Clear overrides an in_val in the same cycle.
    drive_all(4);
    clr = 1'b1;
    drive_all(50);
    clr = 1'b0;
    check("clr_state", {out_val, out_blk, out_last, d11, d12, d21, d22, ovf, busy}, 64'd0);
    push_exp(0, 1'b0, 2, 2, 2, 2);
    drive_all(1); drive_all(1);
    idle(); idle();
    check("clr_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
